// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch stage: streams bytes from a 1-cycle-latency memory into a
// circular byte queue and presents opcode plus ARGS argument bytes at pc.
module instr_prefetch_unit #(
  parameter int unsigned        ADDR_W   = 8,
  parameter int unsigned        ARGS     = 2,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_rd_en,
  input  logic [7:0]                  mem_rdata,
  output logic [7:0]                  op_code,
  output logic [ARGS*8-1:0]           args,
  output logic [ADDR_W-1:0]           pc,
  output logic                        valid,
  input  logic                        advance,
  input  logic [$clog2(ARGS+2)-1:0]   adv_len,
  input  logic                        jump_en,
  input  logic [ADDR_W-1:0]           jump_target
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned LEN_W = $clog2(ARGS + 2);

  if (DEPTH < ARGS + 2) begin : g_bad_depth
    $error("instr_prefetch_unit: DEPTH must be >= ARGS+2");
  end

  logic [7:0]        qmem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic              inflight;
  logic [ADDR_W-1:0] fetch_addr;
  logic              adv_ok;
  logic [CNT_W-1:0]  pop_len;
  logic [CNT_W:0]    occ;
  logic [CNT_W:0]    lim;

  // Circular pointer add; n never exceeds DEPTH-1 so one subtraction suffices.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [PTR_W:0]   n);
    logic [PTR_W:0] s;
    s = {1'b0, p} + n;
    if (s >= (PTR_W+1)'(DEPTH)) s = s - (PTR_W+1)'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

  // Issue/accept decisions; the read slot freed by a same-cycle pop is reusable.
  always_comb begin
    valid     = (count >= CNT_W'(ARGS + 1));
    adv_ok    = advance && valid && !jump_en && (adv_len != '0) &&
                (adv_len <= LEN_W'(ARGS + 1));
    pop_len   = adv_ok ? CNT_W'(adv_len) : '0;
    occ       = (CNT_W+1)'(count) + (CNT_W+1)'(inflight);
    lim       = (CNT_W+1)'(DEPTH) + (CNT_W+1)'(pop_len);
    mem_rd_en = !rst && !jump_en && (occ < lim);
  end

  assign mem_addr = fetch_addr;

  always_comb begin
    op_code = '0;
    args    = '0;
    if (valid) begin
      op_code = qmem[head];
      for (int unsigned i = 0; i < ARGS; i++) begin
        args[i*8 +: 8] = qmem[ptr_add(head, (PTR_W+1)'(i + 1))];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !jump_en && inflight) qmem[tail] <= mem_rdata;
  end

  // A jump drops queue contents and marks the outstanding read as stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      inflight   <= 1'b0;
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
    end else if (jump_en) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      inflight   <= 1'b0;
      pc         <= jump_target;
      fetch_addr <= jump_target;
    end else begin
      inflight <= mem_rd_en;
      if (mem_rd_en) fetch_addr <= fetch_addr + ADDR_W'(1);
      if (inflight) tail <= ptr_add(tail, (PTR_W+1)'(1));
      if (adv_ok) begin
        head <= ptr_add(head, (PTR_W+1)'(adv_len));
        pc   <= pc + ADDR_W'(adv_len);
      end
      count <= count + CNT_W'(inflight) - pop_len;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Bench for instr_prefetch_unit: memory model, address-tracking scoreboard,
// vector table for advance/jump, and hand sequences for fill/jump/wrap/reset timing.
module tb_instr_prefetch_unit;

  logic        clk;
  logic        rst;
  logic [7:0]  mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_rdata;
  logic [7:0]  op_code;
  logic [15:0] args;
  logic [7:0]  pc;
  logic        valid;
  logic        advance;
  logic [1:0]  adv_len;
  logic        jump_en;
  logic [7:0]  jump_target;

  instr_prefetch_unit #(.ADDR_W(8), .ARGS(2), .DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .op_code(op_code), .args(args), .pc(pc), .valid(valid),
    .advance(advance), .adv_len(adv_len), .jump_en(jump_en), .jump_target(jump_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] tb_mem [256];

  // Synchronous memory, one cycle of read latency.
  always @(posedge clk) mem_rdata <= mem_rd_en ? tb_mem[mem_addr] : 8'hEE;

  typedef struct {
    logic [7:0]  pc;
    logic [7:0]  op;
    logic [15:0] args;
  } instr_t;

  typedef struct {
    logic       jump;
    logic [7:0] tgt;
    logic       adv;
    logic [1:0] len;
    logic [7:0] exp_pc;
  } vec_t;

  instr_t     exp_q[$];
  vec_t       vt[7];
  logic [7:0] m_pc;
  int         n_chk;
  int         n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_expect();
    instr_t e;
    e.pc   = m_pc;
    e.op   = tb_mem[m_pc];
    e.args = {tb_mem[8'(m_pc + 8'd2)], tb_mem[8'(m_pc + 8'd1)]};
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input string name);
    #1;
    for (int t = 0; t < 40 && !valid; t++) begin
      @(negedge clk);
      #1;
    end
    if (!valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: valid never asserted", name);
    end
  endtask

  task automatic check_instr(input string name);
    instr_t e;
    wait_valid(name);
    e = exp_q.pop_front();
    chk($sformatf("%s_pc", name), 32'(pc), 32'(e.pc));
    chk($sformatf("%s_op", name), 32'(op_code), 32'(e.op));
    chk($sformatf("%s_args", name), 32'(args), 32'(e.args));
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    advance = 1'b0;
    adv_len = 2'd0;
    jump_en = 1'b0;
    jump_target = 8'h00;
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'(i) ^ 8'hA5;
    for (int i = 0; i < 8; i++) tb_mem[i] = 8'(8'h10 * (i + 1));
    tb_mem[8'h80] = 8'hAA; tb_mem[8'h81] = 8'hBB; tb_mem[8'h82] = 8'hCC;
    tb_mem[8'hFE] = 8'h01; tb_mem[8'hFF] = 8'h02;

    vt[0] = '{jump: 1'b1, tgt: 8'h00, adv: 1'b0, len: 2'd0, exp_pc: 8'h00};
    vt[1] = '{jump: 1'b0, tgt: 8'h00, adv: 1'b1, len: 2'd3, exp_pc: 8'h03};
    vt[2] = '{jump: 1'b0, tgt: 8'h00, adv: 1'b1, len: 2'd0, exp_pc: 8'h03};
    vt[3] = '{jump: 1'b0, tgt: 8'h00, adv: 1'b1, len: 2'd2, exp_pc: 8'h05};
    vt[4] = '{jump: 1'b0, tgt: 8'h00, adv: 1'b1, len: 2'd1, exp_pc: 8'h06};
    vt[5] = '{jump: 1'b1, tgt: 8'h40, adv: 1'b1, len: 2'd1, exp_pc: 8'h40};
    vt[6] = '{jump: 1'b0, tgt: 8'h00, adv: 1'b1, len: 2'd3, exp_pc: 8'h43};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_op", 32'(op_code), 32'h00);
    chk("rst_args", 32'(args), 32'h0000);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);

    // Fill after release: reads in k..k+3, valid from k+4
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("fill_addr0", 32'(mem_addr), 32'h00);
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      chk($sformatf("fill_valid_k%0d", i), 32'(valid), (i >= 4) ? 32'd1 : 32'd0);
      chk($sformatf("fill_rd_en_k%0d", i), 32'(mem_rd_en), (i <= 3) ? 32'd1 : 32'd0);
    end
    m_pc = 8'h00;
    push_expect();
    check_instr("fill");
    chk("fill_args_const", 32'(args), 32'h3020);

    // Sustained single-byte advance
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      advance = 1'b1;
      adv_len = 2'd1;
      #1;
      chk($sformatf("sus_valid%0d", i), 32'(valid), 32'd1);
      chk($sformatf("sus_pc%0d", i), 32'(pc), 32'(i));
      chk($sformatf("sus_op%0d", i), 32'(op_code), 32'(8'h10 * (i + 1)));
      m_pc = m_pc + 8'd1;
    end
    @(negedge clk);
    advance = 1'b0;
    adv_len = 2'd0;
    chk("sus_valid_after", 32'(valid), 32'd1);

    // Vector table
    for (int n = 0; n < 7; n++) begin
      push_expect();
      check_instr($sformatf("v%0d_pre", n));
      @(negedge clk);
      jump_en = vt[n].jump;
      jump_target = vt[n].tgt;
      advance = vt[n].adv;
      adv_len = vt[n].len;
      @(negedge clk);
      jump_en = 1'b0;
      advance = 1'b0;
      adv_len = 2'd0;
      if (vt[n].jump) m_pc = vt[n].tgt;
      else if (vt[n].adv && vt[n].len != 2'd0) m_pc = m_pc + 8'(vt[n].len);
      wait_valid($sformatf("v%0d_post", n));
      chk($sformatf("v%0d_pc", n), 32'(pc), 32'(vt[n].exp_pc));
    end

    // Jump with simultaneous advance: advance dropped, valid at j+5
    push_expect();
    check_instr("jmp_pre");
    @(negedge clk);
    jump_en = 1'b1;
    jump_target = 8'h80;
    advance = 1'b1;
    adv_len = 2'd1;
    @(negedge clk);
    jump_en = 1'b0;
    advance = 1'b0;
    adv_len = 2'd0;
    #1;
    chk("jmp_valid_j1", 32'(valid), 32'd0);
    chk("jmp_rd_en_j1", 32'(mem_rd_en), 32'd1);
    chk("jmp_addr_j1", 32'(mem_addr), 32'h80);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("jmp_valid_j%0d", i), 32'(valid), 32'd0);
    end
    @(negedge clk);
    #1;
    chk("jmp_valid_j5", 32'(valid), 32'd1);
    chk("jmp_args_const", 32'(args), 32'hCCBB);
    m_pc = 8'h80;
    push_expect();
    check_instr("jmp");

    // Wrap across address 0xFF -> 0x00
    tb_mem[8'h00] = 8'h03;
    @(negedge clk);
    jump_en = 1'b1;
    jump_target = 8'hFE;
    @(negedge clk);
    jump_en = 1'b0;
    m_pc = 8'hFE;
    push_expect();
    check_instr("wrap");
    chk("wrap_args_const", 32'(args), 32'h0302);
    @(negedge clk);
    advance = 1'b1;
    adv_len = 2'd2;
    @(negedge clk);
    advance = 1'b0;
    adv_len = 2'd0;
    m_pc = 8'h00;
    push_expect();
    check_instr("wrap_adv");

    // Reset mid-operation, then refill from mem[0]
    tb_mem[8'h00] = 8'h10;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mrst_valid", 32'(valid), 32'd0);
    chk("mrst_pc", 32'(pc), 32'h00);
    chk("mrst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("mrst_op", 32'(op_code), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      chk($sformatf("mrst_valid_k%0d", i), 32'(valid), (i == 4) ? 32'd1 : 32'd0);
    end
    m_pc = 8'h00;
    push_expect();
    check_instr("mrst_refill");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_unit.md
Name: instr_prefetch_unit

Overview:
Parametrised instruction fetch stage for the bytecode CPU. It replaces the ad-hoc byte fetch that presented op_code/arg1/arg2 straight from memory at pc. The block streams bytes from a synchronous 1-cycle-latency instruction memory into a prefetch queue. It presents the opcode plus ARGS argument bytes with a valid flag, and supports variable-length advance and branch flush.

Parameters:
ADDR_W, 8, instruction address width; all address arithmetic is modulo 2^ADDR_W.
ARGS, 2, argument bytes presented after the opcode (>=1).
DEPTH, 4, prefetch queue depth in bytes; must be >= ARGS+2 (checked by elaboration assertion).
RESET_PC, 0, fetch address after reset.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
mem_addr  out  ADDR_W  instruction memory read address.
mem_rd_en  out  1  read strobe; data returns on mem_rdata in the next cycle.
mem_rdata  in  8  read data, valid the cycle after mem_rd_en.
op_code  out  8  byte at pc.
args  out  ARGS*8  bytes pc+1..pc+ARGS; arg1 in [7:0], arg2 in [15:8], and so on.
pc  out  ADDR_W  address of op_code.
valid  out  1  op_code and all ARGS bytes are present in the queue.
advance  in  1  consume the current instruction.
adv_len  in  $clog2(ARGS+2)  bytes consumed, legal range 1..ARGS+1.
jump_en  in  1  redirect fetch.
jump_target  in  ADDR_W  new pc.

Behaviour:
- Reset (rst=1 at an edge):
  - queue empty; in-flight count 0; pc=RESET_PC; fetch address=RESET_PC.
  - valid=0, mem_rd_en=0, op_code=0, args=0.
  - Reset overrides jump and advance. Reset mid-fill drops in-flight data.
- Queue: circular byte buffer with count 0..DEPTH. The head is always the byte at pc.
- Fetch issue:
  - mem_rd_en=1 when count + inflight − pop < DEPTH, where pop = adv_len if an accepted advance occurs this cycle, else 0.
  - mem_addr = fetch address. The fetch address increments (wraps) on each issue.
- Capture: a byte returning on mem_rdata is pushed at the tail in the cycle after issue, unless discarded by a flush.
- valid = (count >= ARGS+1). op_code and args are driven from the queue head; they are 0 when valid=0.
- Advance:
  - Accepted only when valid=1, jump_en=0, and 1 <= adv_len <= ARGS+1.
  - On accept: pop adv_len bytes; pc += adv_len (wraps).
  - Otherwise advance is ignored with no state change.
  - A push and a pop in the same cycle are both honoured.
- Jump (jump_en=1 in cycle j, no reset):
  - pc and fetch address load jump_target; queue cleared; valid=0 from cycle j+1.
  - Any read in flight at edge j is discarded when it returns.
  - First new read is issued in cycle j+1. Jump has priority over a simultaneous advance.
- Latency:
  - First cycle after reset release = k. Reads are issued k, k+1, ...; valid first asserts in cycle k+ARGS+2.
  - After a jump in cycle j, valid asserts at j+ARGS+3.
- Throughput: with DEPTH >= ARGS+2 and advance with adv_len=1 every valid cycle, valid stays high continuously after the initial fill.
- Wrap-around: fetch address ADDR_W'(2^ADDR_W−1) is followed by 0; args spanning the wrap read the low addresses.
- Fetch never stalls on memory; the memory is always ready.

Test Plan:
- Reset fill: mem[0..7]=10,20,30,40,50,60,70,80; release rst at cycle k, no advance → valid=1 at k+4 with op_code=10, args=16'h3020, pc=0. mem_rd_en drops once count+inflight=4.
- Sustained advance: from the fill state, advance=1, adv_len=1 every cycle for 5 cycles → valid never drops; op_code sequence 10,20,30,40,50; pc 0..4.
- Variable length: at pc=0, adv_len=3 → next valid op_code=40, args=16'h6050, pc=3. adv_len=0 or adv_len=4 → ignored, pc unchanged.
- Jump with advance: mem[0x80]=AA,BB,CC; assert jump_en (target 0x80) and advance in the same cycle j → the advance is ignored; valid=0 at j+1..j+4. At j+5: op_code=AA, args=16'hCCBB, pc=0x80. No stale pre-jump byte appears.
- Wrap: mem[0xFE]=01, mem[0xFF]=02, mem[0x00]=03; jump to 0xFE → op_code=01, args=16'h0302. Advance len 2 → pc=0x00.
- Reset mid-operation: assert rst while valid=1 with reads in flight → next cycle valid=0, pc=RESET_PC, mem_rd_en=0. After release, refill shows mem[0] data only.
